// File: rtl/operand_issue_pkg.sv
// operand_issue_pkg: shared state encoding and sizing constants for the operand feeder
package operand_issue_pkg;
  typedef enum logic [2:0] {GET_A, GET_B, GET_C, GET_D, ISSUE} state_e;
  localparam int DEF_WIDTH = 10;
  localparam int DEF_CNT_W = 8;
  localparam int ARITH_PIPE_LAT = 2;
endpackage

// File: rtl/operand_issue_if.sv
// operand_issue_if: serial beat input, parallel operand issue and result return bundle
interface operand_issue_if #(
  parameter int WIDTH = operand_issue_pkg::DEF_WIDTH,
  parameter int CNT_W = operand_issue_pkg::DEF_CNT_W
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A, B, C, D;
  logic             issue_valid;
  logic [WIDTH-1:0] f_in;
  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic [CNT_W-1:0] issue_count;
  modport master (
    output in_data, in_valid, f_in,
    input  in_ready, A, B, C, D, issue_valid, res_data, res_valid, issue_count
  );
  modport slave (
    input  in_data, in_valid, f_in,
    output in_ready, A, B, C, D, issue_valid, res_data, res_valid, issue_count
  );
endinterface

// File: rtl/operand_issue_valid_delay_line.sv
// valid_delay_line: DEPTH-deep 1-bit shift register with synchronous reset
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr_q, sr_d;
  always_comb sr_d = (sr_q << 1) | DEPTH'(d);
  always_ff @(posedge clk) sr_q <= rst ? '0 : sr_d;
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/operand_issue.sv
// operand_issue: gathers serial A..D beats, issues them as one set and captures the returning F
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PIPE_LAT = ARITH_PIPE_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  operand_issue_if.slave bus
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, res_data_q, res_data_d;
  logic res_valid_q, res_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic issuing, acc, tag_out;
  always_comb begin
    issuing = state_q == ISSUE;
    acc = bus.in_valid && !issuing;
    state_d = issuing ? GET_A : acc ? state_e'(state_q + 3'd1) : state_q;
    a_d = (acc && state_q == GET_A) ? bus.in_data : a_q;
    b_d = (acc && state_q == GET_B) ? bus.in_data : b_q;
    c_d = (acc && state_q == GET_C) ? bus.in_data : c_q;
    d_d = (acc && state_q == GET_D) ? bus.in_data : d_q;
    cnt_d = issuing ? cnt_q + 1'b1 : cnt_q;
    res_valid_d = tag_out;
    res_data_d = tag_out ? bus.f_in : res_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end
  // tag marks which edge the arithmetic unit's F belongs to an issued set
  valid_delay_line #(.DEPTH(PIPE_LAT)) u_tag (
    .clk (clk),
    .rst (rst),
    .d   (issuing),
    .q   (tag_out)
  );
  assign bus.in_ready    = !issuing;
  assign bus.issue_valid = issuing;
  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.C           = c_q;
  assign bus.D           = d_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.issue_count = cnt_q;
endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue: directed stimulus with a cycle-level beat/result model and literal spot checks
module tb_operand_issue;
  import operand_issue_pkg::*;
  localparam int W  = DEF_WIDTH;
  localparam int CW = DEF_CNT_W;
  localparam int PL = ARITH_PIPE_LAT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  operand_issue_if #(.WIDTH(W), .CNT_W(CW)) bus();
  operand_issue #(.WIDTH(W), .PIPE_LAT(PL), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int errors  = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  // model: beats collected so far, issue when four are held, results due PL cycles after issue
  int cyc = 0;
  int m_cnt = 0;
  logic [W-1:0] m_ops [4];
  int m_count = 0;
  logic [W-1:0] m_res = '0;
  bit m_rv = 1'b0;
  bit m_live = 1'b0;
  int pend[$];
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      m_ops = '{default: '0};
      m_count = 0;
      m_res = '0;
      m_rv = 1'b0;
      pend.delete();
      m_live = 1'b1;
    end else begin
      m_rv = 1'b0;
      if (pend.size() > 0 && pend[0] == cyc - PL) begin
        m_rv = 1'b1;
        m_res = bus.f_in;
        void'(pend.pop_front());
      end
      if (m_cnt == 4) begin
        m_count++;
        pend.push_back(cyc);
        m_cnt = 0;
      end else if (bus.in_valid) begin
        m_ops[m_cnt] = bus.in_data;
        m_cnt++;
      end
    end
    cyc++;
  end
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_cnt != 4));
      chk("issue_valid", 32'(bus.issue_valid), 32'(m_cnt == 4));
      chk("A", 32'(bus.A), 32'(m_ops[0]));
      chk("B", 32'(bus.B), 32'(m_ops[1]));
      chk("C", 32'(bus.C), 32'(m_ops[2]));
      chk("D", 32'(bus.D), 32'(m_ops[3]));
      chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
      chk("res_data", 32'(bus.res_data), 32'(m_res));
      chk("issue_count", 32'(bus.issue_count), 32'(m_count % (1 << CW)));
    end
  end
  bit f_hold = 1'b0;
  logic [W-1:0] f_val = '0;
  always @(posedge clk) begin
    #1;
    bus.f_in = f_hold ? f_val : W'($urandom);
  end
  task automatic send(input logic [W-1:0] v);
    bit r;
    bus.in_valid = 1'b1;
    bus.in_data = v;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) return;
    end
    vectors++;
    errors++;
    $display("FAIL accept_timeout: beat %0d never accepted", v);
  endtask
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_data = W'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_set(input string tag, input int a, input int b, input int c, input int d);
    @(negedge clk);
    chk({tag, "_issue"}, 32'(bus.issue_valid), 1);
    chk({tag, "_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_A"}, 32'(bus.A), a);
    chk({tag, "_B"}, 32'(bus.B), b);
    chk({tag, "_C"}, 32'(bus.C), c);
    chk({tag, "_D"}, 32'(bus.D), d);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_issue", 32'(bus.issue_valid), 0);
    chk("rst_A", 32'(bus.A), 0);
    chk("rst_D", 32'(bus.D), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_count", 32'(bus.issue_count), 0);
    @(posedge clk);
    #1;
    send(10); send(12); send(6); send(3);
    bus.in_valid = 1'b0;
    chk_set("set1", 10, 12, 6, 3);
    @(negedge clk);
    chk("set1_count", 32'(bus.issue_count), 1);
    f_hold = 1'b1;
    f_val = 10'd55;
    @(negedge clk);
    chk("set1_res_early", 32'(bus.res_valid), 0);
    f_hold = 1'b0;
    @(negedge clk);
    chk("set1_res_valid", 32'(bus.res_valid), 1);
    chk("set1_res_data", 32'(bus.res_data), 55);
    @(negedge clk);
    chk("set1_res_once", 32'(bus.res_valid), 0);
    chk("set1_res_hold", 32'(bus.res_data), 55);
    @(posedge clk);
    #1;
    send(10); idle(1); send(10); idle(1); send(5); idle(2); send(3);
    bus.in_valid = 1'b0;
    chk_set("gap", 10, 10, 5, 3);
    @(posedge clk);
    #1;
    idle(6);
    send(10); send(12); send(6); send(3);
    send(20); send(11); send(1); send(4);
    bus.in_valid = 1'b0;
    chk_set("b2b", 20, 11, 1, 4);
    @(posedge clk);
    #1;
    idle(6);
    chk("b2b_count", 32'(bus.issue_count), 4);
    send(5); send(6); send(7); send(8);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1); send(2);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_res_valid", 32'(bus.res_valid), 0);
    end
    @(posedge clk);
    #1;
    send(7); send(8); send(9); send(1);
    bus.in_valid = 1'b0;
    chk_set("post_rst", 7, 8, 9, 1);
    chk("post_rst_count", 32'(bus.issue_count), 0);
    @(posedge clk);
    #1;
    idle(6);
    for (int s = 0; s < 255; s++) begin
      for (int k = 0; k < 4; k++) send(W'($urandom));
    end
    idle(3);
    chk("wrap_zero", 32'(bus.issue_count), 0);
    for (int k = 0; k < 4; k++) send(W'(k + 1));
    idle(3);
    chk("wrap_next", 32'(bus.issue_count), 1);
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Upstream feeder for the 4-operand pipelined arithmetic unit (inputs A, B, C, D, output F, port clk).
- Accepts operands serially on one WIDTH-bit bus with a valid/ready handshake.
- Assembles each group into a parallel set A..D and issues it to the pipeline for one cycle.
- Tracks in-flight sets through a PIPE_LAT-deep tag pipeline, so each returning F is captured with a matching valid strobe.

Parameters:
- WIDTH, 10, operand and result width.
- PIPE_LAT, 2, clock edges from operands sampled by the arithmetic unit to F valid (minimum 1).
- CNT_W, 8, width of the issued-set counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  serial operand beat, ordered A, B, C, D.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  block accepts a beat this cycle.
- A  out  WIDTH  operand A to the arithmetic unit.
- B  out  WIDTH  operand B to the arithmetic unit.
- C  out  WIDTH  operand C to the arithmetic unit.
- D  out  WIDTH  operand D to the arithmetic unit.
- issue_valid  out  1  A..D form a complete new set this cycle.
- f_in  in  WIDTH  F returned from the arithmetic unit.
- res_data  out  WIDTH  captured result.
- res_valid  out  1  one-cycle strobe; res_data is new.
- issue_count  out  CNT_W  number of sets issued since reset, wraps.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state GET_A; A, B, C, D, res_data = 0; issue_valid = 0; res_valid = 0; tag pipeline = 0; issue_count = 0.
  - in_ready = 1 in the first cycle after rst deasserts.
- State machine: GET_A -> GET_B -> GET_C -> GET_D -> ISSUE -> GET_A.
  - A beat is accepted when in_valid && in_ready.
  - Each GET_x state advances only on an accepted beat and loads the matching operand register.
  - Without an accepted beat, the state holds and registers are unchanged.
- in_ready: 1 in every GET_x state, 0 in ISSUE.
  - in_ready is a function of state only; it must not depend on in_valid.
  - A beat offered during ISSUE is not accepted; the source holds it.
- ISSUE lasts exactly one cycle.
  - issue_valid = 1 only in ISSUE; issue_count increments at the end of ISSUE.
  - Peak throughput: one set per 5 cycles.
- Operand registers are stable during the ISSUE cycle.
  - They are loaded only by accepted beats.
  - After issue they hold their values until overwritten by the next set (A changes first).
- Tag pipeline: tag[0] <= issue_valid; tag[i] <= tag[i-1]; depth PIPE_LAT.
  - When tag[PIPE_LAT-1] = 1: at that edge res_data <= f_in and res_valid <= 1; otherwise res_valid <= 0.
  - Result: issue_valid high in cycle N gives res_valid high in cycle N+PIPE_LAT+1, for exactly one cycle.
  - res_data holds between strobes.
- Results never reorder or overlap. Issue spacing (5) exceeds the strobe width, so at most one strobe per cycle.
- rst mid-operation:
  - Partial operand group discarded.
  - Tag pipeline flushed; no res_valid is produced for any set issued before reset.
  - Next accepted beat is treated as A.
- issue_count wraps from 2^CNT_W-1 to 0 with no flag.
- f_in is ignored except at tag-capture edges.

Decomposition:
- Shared package holds:
  - the state enum (GET_A, GET_B, GET_C, GET_D, ISSUE);
  - the default WIDTH;
  - the PIPE_LAT constant matching the arithmetic unit, shared by this block and its bench.
- One sub-module, valid_delay_line: a parameterised PIPE_LAT-deep 1-bit shift register with synchronous reset, carrying the tag.

Test Plan:
- Reset check: hold rst 2 cycles, then release.
  - Required: in_ready=1, issue_valid=0, A=B=C=D=0, res_valid=0, issue_count=0.
- Back-to-back beats 10, 12, 6, 3 with in_valid continuously high.
  - Required: issue_valid pulses one cycle (cycle N) with A=10, B=12, C=6, D=3, and in_ready=0 in that cycle.
  - Bench drives f_in=55 in cycle N+2.
  - Required: res_data=55 and res_valid=1 only in cycle N+3; issue_count=1.
- Gapped beats 10, idle, 10, idle, 5, idle, idle, 3.
  - Required: only valid beats captured; issue gives A=10, B=10, C=5, D=3; no issue before the fourth beat.
- Two sets back to back: 10, 12, 6, 3 then 20, 11, 1, 4, with in_valid held high during ISSUE.
  - Required: issue_valid pulses 5 cycles apart; second set is A=20, B=11, C=1, D=4; no beat lost or duplicated.
  - Required: two res_valid pulses 5 cycles apart; issue_count=2.
- Reset in flight: assert rst in the cycle after an issue, and again while in GET_C of a partial set.
  - Required: no res_valid afterwards for either set.
  - Then feeding 7, 8, 9, 1 must issue A=7, B=8, C=9, D=1.
- Counter wrap: issue 256 sets with CNT_W=8.
  - Required: issue_count returns to 0 and keeps counting.
